// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive line decoder.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECEIVE,
    EOP_WAIT,
    ERROR_WAIT
  } rx_state_t;

  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;
  localparam int unsigned IDLE_J_COUNT = 8;

  // SE1 is an illegal line state and is folded onto SE0.
  function automatic logic [1:0] line_state(input logic dp, input logic dm);
    return (dp ^ dm) ? {dp, dm} : LINE_SE0;
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Bit-period timer: restarts on every D+ transition and strobes once per bit
// near the middle of the bit period, free-running through runs without edges.
module usb_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic dp,
  output logic sample
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             dp_prev;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count + CNT_W'(1);
    if ((dp != dp_prev) || (count == CNT_MAX)) begin
      count_next = '0;
    end
  end

  // dp_prev resets high to match the idle-J value of the synchroniser.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_prev <= 1'b1;
      count   <= '0;
      sample  <= 1'b0;
    end else begin
      dp_prev <= dp;
      count   <= count_next;
      sample  <= (count_next == CNT_SAMPLE);
    end
  end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive line decoder: input synchronisation, bit recovery,
// NRZI decode, bit unstuffing, SYNC/EOP framing and byte assembly.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_J_COUNT);
  localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(STUFF_LIMIT);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_J_COUNT - 1);

  logic [1:0]        dp_sync;
  logic [1:0]        dm_sync;
  logic              sample;
  logic [1:0]        line_c;
  logic              is_j;
  logic              is_k;
  logic              is_se0;
  logic              bit_c;
  logic [7:0]        byte_c;
  logic              fail_c;

  rx_state_t         state;
  logic              last_j;
  logic [2:0]        bit_cnt;
  logic [ONES_W-1:0] ones_cnt;
  logic [1:0]        se0_cnt;
  logic [IDLE_W-1:0] j_cnt;
  logic [6:0]        shift;

  // Two-flop synchroniser, reset to the idle J level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_sync <= 2'b11;
      dm_sync <= 2'b00;
    end else begin
      dp_sync <= {dp_sync[0], dp_in};
      dm_sync <= {dm_sync[0], dm_in};
    end
  end

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .dp    (dp_sync[1]),
    .sample(sample)
  );

  // Line classification, NRZI decode and the byte that would complete on this sample.
  always_comb begin
    line_c = line_state(dp_sync[1], dm_sync[1]);
    is_j   = (line_c == LINE_J);
    is_k   = (line_c == LINE_K);
    is_se0 = (line_c == LINE_SE0);
    bit_c  = (is_j == last_j);
    byte_c = {bit_c, shift};
  end

  // Every framing/stuffing violation funnels here so errors pre-empt data and EOP.
  always_comb begin
    fail_c = 1'b0;
    case (state)
      SYNC:     fail_c = is_se0 || ((bit_cnt == 3'd7) && (byte_c != SYNC_PATTERN));
      RECEIVE:  fail_c = is_se0 ? (bit_cnt != 3'd0) : ((ones_cnt == ONES_STUFF) && bit_c);
      EOP_WAIT: fail_c = is_se0 ? (se0_cnt == 2'd3) : !(is_j && (se0_cnt >= 2'd2));
      default:  fail_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      last_j        <= 1'b1;
      bit_cnt       <= '0;
      ones_cnt      <= '0;
      se0_cnt       <= '0;
      j_cnt         <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_active     <= 1'b0;
      rx_eop        <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      rx_eop        <= 1'b0;
      rx_error      <= 1'b0;
      if (sample) begin
        if (!is_se0) begin
          last_j <= is_j;
        end
        if (fail_c) begin
          state     <= ERROR_WAIT;
          rx_error  <= 1'b1;
          rx_active <= 1'b0;
          j_cnt     <= '0;
        end else begin
          case (state)
            IDLE: begin
              // The first K is already bit 0 of the SYNC field.
              if (is_k) begin
                shift   <= byte_c[7:1];
                bit_cnt <= 3'd1;
                state   <= SYNC;
              end
            end
            SYNC: begin
              if (bit_cnt == 3'd7) begin
                state     <= RECEIVE;
                rx_active <= 1'b1;
                bit_cnt   <= '0;
                ones_cnt  <= '0;
              end else begin
                shift   <= byte_c[7:1];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            RECEIVE: begin
              if (is_se0) begin
                state   <= EOP_WAIT;
                se0_cnt <= 2'd1;
              end else if (ones_cnt == ONES_STUFF) begin
                ones_cnt <= '0;
              end else begin
                shift    <= byte_c[7:1];
                bit_cnt  <= bit_cnt + 3'd1;
                ones_cnt <= bit_c ? ones_cnt + ONES_W'(1) : '0;
                if (bit_cnt == 3'd7) begin
                  rx_data       <= byte_c;
                  rx_data_valid <= 1'b1;
                end
              end
            end
            EOP_WAIT: begin
              if (is_se0) begin
                se0_cnt <= se0_cnt + 2'd1;
              end else begin
                rx_eop    <= 1'b1;
                rx_active <= 1'b0;
                state     <= IDLE;
              end
            end
            ERROR_WAIT: begin
              if (!is_j) begin
                j_cnt <= '0;
              end else if (j_cnt == IDLE_LAST) begin
                j_cnt <= '0;
                state <= IDLE;
              end else begin
                j_cnt <= j_cnt + IDLE_W'(1);
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: a small NRZI/stuffing line driver
// plus per-scenario tasks comparing pulse counts and bytes to hand-derived values.
module tb_usb_rx_bit_decoder;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       dp_in;
  logic       dm_in;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int eop_cnt = 0;
  int err_cnt = 0;
  int active_cnt = 0;
  logic [7:0] data_q[$];

  logic tb_j;
  int   tb_ones;

  always #5 clk = ~clk;

  usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .dp_in        (dp_in),
    .dm_in        (dm_in),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_active    (rx_active),
    .rx_eop       (rx_eop),
    .rx_error     (rx_error)
  );

  // Pulse counters and received-byte log, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_data_valid) begin
      data_q.push_back(rx_data);
      valid_cnt++;
    end
    if (rx_eop) eop_cnt++;
    if (rx_error) err_cnt++;
    if (rx_active) active_cnt++;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // NRZI: a 0 toggles the line, a 1 keeps it.
  task automatic send_raw(input bit b, input int len);
    if (!b) tb_j = ~tb_j;
    {dp_in, dm_in} = tb_j ? 2'b10 : 2'b01;
    hold(len);
  endtask

  task automatic send_data_bit(input bit b, input int len);
    send_raw(b, len);
    tb_ones = b ? tb_ones + 1 : 0;
    if (tb_ones == 6) begin
      send_raw(1'b0, CPB);
      tb_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i], CPB);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_raw(1'b0, CPB);
    send_raw(1'b1, CPB);
    tb_ones = 0;
  endtask

  task automatic send_eop();
    {dp_in, dm_in} = 2'b00;
    hold(2 * CPB);
    tb_j = 1'b1;
    {dp_in, dm_in} = 2'b10;
    hold(CPB);
  endtask

  task automatic send_idle(input int n);
    tb_j = 1'b1;
    {dp_in, dm_in} = 2'b10;
    hold(n * CPB);
  endtask

  task automatic send_packet(input logic [7:0] v);
    send_sync();
    send_byte(v);
    send_eop();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tb_j = 1'b1;
    tb_ones = 0;
    {dp_in, dm_in} = 2'b10;
    @(negedge clk);
    hold(4);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_data_valid); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", rx_active); end
    checks++; if (rx_eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b want 0", rx_eop); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", rx_error); end
    n_rst = 1'b1;
    send_idle(4);
  endtask

  task automatic test_basic();
    int v0, e0, r0;
    logic [7:0] got;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    for (int i = 0; i < 7; i++) send_raw(1'b0, CPB);
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL basic_active_early got %b want 0", rx_active); end
    send_raw(1'b1, CPB);
    tb_ones = 0;
    checks++; if (rx_active !== 1'b1) begin errors++; $display("FAIL basic_active_after_sync got %b want 1", rx_active); end
    send_byte(8'hA5);
    send_eop();
    send_idle(4);
    got = (data_q.size() > v0) ? data_q[v0] : 8'hxx;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got %0d want 1", valid_cnt - v0); end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", got); end
    checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL basic_eop_count got %0d want 1", eop_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL basic_error_count got %0d want 0", err_cnt - r0); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL basic_active_after_eop got %b want 0", rx_active); end
  endtask

  task automatic test_stuffing();
    int v0, e0, r0;
    logic [7:0] got0, got1;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h3F);
    send_eop();
    send_idle(4);
    got0 = (data_q.size() > v0) ? data_q[v0] : 8'hxx;
    got1 = (data_q.size() > v0 + 1) ? data_q[v0 + 1] : 8'hxx;
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL stuff_valid_count got %0d want 2", valid_cnt - v0); end
    checks++; if (got0 !== 8'hFF) begin errors++; $display("FAIL stuff_data0 got %h want ff", got0); end
    checks++; if (got1 !== 8'h3F) begin errors++; $display("FAIL stuff_data1 got %h want 3f", got1); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL stuff_error_count got %0d want 0", err_cnt - r0); end
    checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL stuff_eop_count got %0d want 1", eop_cnt - e0); end
  endtask

  task automatic test_stuff_error();
    int v0, e0, r0;
    logic [7:0] got;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    send_sync();
    for (int i = 0; i < 7; i++) send_raw(1'b1, CPB);
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL stufferr_error_count got %0d want 1", err_cnt - r0); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL stufferr_active got %b want 0", rx_active); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL stufferr_valid_count got %0d want 0", valid_cnt - v0); end
    // Fewer than 8 idle J bit-times: the following packet must be ignored.
    send_idle(5);
    send_packet(8'h11);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL stufferr_early_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (eop_cnt - e0 !== 0) begin errors++; $display("FAIL stufferr_early_eop got %0d want 0", eop_cnt - e0); end
    send_idle(10);
    send_packet(8'h66);
    send_idle(4);
    got = (data_q.size() > v0) ? data_q[v0] : 8'hxx;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL stufferr_recover_valid got %0d want 1", valid_cnt - v0); end
    checks++; if (got !== 8'h66) begin errors++; $display("FAIL stufferr_recover_data got %h want 66", got); end
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL stufferr_total_errors got %0d want 1", err_cnt - r0); end
  endtask

  task automatic test_se0_mid_byte();
    int v0, e0, r0;
    logic [7:0] partial;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    partial = 8'h15;
    send_sync();
    for (int i = 0; i < 5; i++) send_data_bit(partial[i], CPB);
    send_eop();
    send_idle(10);
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL se0mid_error_count got %0d want 1", err_cnt - r0); end
    checks++; if (eop_cnt - e0 !== 0) begin errors++; $display("FAIL se0mid_eop_count got %0d want 0", eop_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL se0mid_valid_count got %0d want 0", valid_cnt - v0); end
  endtask

  task automatic test_bad_sync();
    int v0, r0, a0;
    v0 = valid_cnt; r0 = err_cnt; a0 = active_cnt;
    for (int i = 0; i < 8; i++) send_raw(1'b0, CPB);
    send_idle(10);
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL badsync_error_count got %0d want 1", err_cnt - r0); end
    checks++; if (active_cnt - a0 !== 0) begin errors++; $display("FAIL badsync_active_cycles got %0d want 0", active_cnt - a0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL badsync_valid_count got %0d want 0", valid_cnt - v0); end
  endtask

  task automatic test_jitter();
    int v0, e0, r0, len;
    logic [7:0] v, got;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    v = 8'h5A;
    send_sync();
    for (int i = 0; i < 8; i++) begin
      len = (i == 0) ? CPB + 1 : ((i == 1) ? CPB - 1 : CPB);
      send_data_bit(v[i], len);
    end
    send_eop();
    send_idle(4);
    got = (data_q.size() > v0) ? data_q[v0] : 8'hxx;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL jitter_valid_count got %0d want 1", valid_cnt - v0); end
    checks++; if (got !== 8'h5A) begin errors++; $display("FAIL jitter_data got %h want 5a", got); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL jitter_error_count got %0d want 0", err_cnt - r0); end
    checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL jitter_eop_count got %0d want 1", eop_cnt - e0); end
  endtask

  task automatic test_reset_mid_packet();
    int v0, e0, r0;
    logic [7:0] v, got;
    v = 8'hC3;
    send_sync();
    for (int i = 0; i < 4; i++) send_data_bit(v[i], CPB);
    checks++; if (rx_active !== 1'b1) begin errors++; $display("FAIL rstmid_active_before got %b want 1", rx_active); end
    n_rst = 1'b0;
    tb_j = 1'b1;
    {dp_in, dm_in} = 2'b10;
    #1;
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b want 0", rx_active); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    checks++; if ({rx_data_valid, rx_eop, rx_error} !== 3'b000) begin
      errors++; $display("FAIL rstmid_pulses got %b want 000", {rx_data_valid, rx_eop, rx_error});
    end
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    @(negedge clk);
    hold(3);
    n_rst = 1'b1;
    tb_ones = 0;
    send_idle(10);
    send_packet(8'h12);
    send_idle(4);
    got = (data_q.size() > v0) ? data_q[v0] : 8'hxx;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rstmid_valid_count got %0d want 1", valid_cnt - v0); end
    checks++; if (got !== 8'h12) begin errors++; $display("FAIL rstmid_data_after got %h want 12", got); end
    checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL rstmid_eop_count got %0d want 1", eop_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL rstmid_error_count got %0d want 0", err_cnt - r0); end
  endtask

  initial begin
    n_rst = 1'b0;
    dp_in = 1'b1;
    dm_in = 1'b0;
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_se0_mid_byte();
    test_bad_sync();
    test_jitter();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
